// File: rtl/led_fade_scheduler.sv
// Colour sequencer for the RGB PWM datapath: steps a Gray-coded colour index,
// fades each duty linearly toward its target per tick, holds, then advances.
module led_fade_scheduler #(
   parameter int COUNTWIDTH = 10,
   parameter int DUTY_MAX   = 50,
   parameter int STEP       = 1,
   parameter int HOLD_TICKS = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  btn_next,
   input  logic                  btn_pause,
   output logic [COUNTWIDTH-1:0] duty_r,
   output logic [COUNTWIDTH-1:0] duty_g,
   output logic [COUNTWIDTH-1:0] duty_b,
   output logic [2:0]            color_idx,
   output logic [1:0]            state,
   output logic                  paused
);

   localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [COUNTWIDTH-1:0] DMAX  = COUNTWIDTH'(DUTY_MAX);
   localparam logic [COUNTWIDTH-1:0] STEPV = COUNTWIDTH'(STEP);
   localparam logic [HW-1:0]         HLAST = HW'(HOLD_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FADE  = 2'd1,
      HOLD  = 2'd2,
      PAUSE = 2'd3
   } state_t;

   state_t                  state_q, state_d, saved_q, saved_d;
   logic [2:0]              idx_q, idx_d, gray;
   logic [HW-1:0]           hold_q, hold_d;
   logic [COUNTWIDTH-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
   logic [COUNTWIDTH-1:0]   tr, tg, tb, fr, fg, fb;

   // Move one STEP toward the target, clamping so it never overshoots or wraps.
   function automatic logic [COUNTWIDTH-1:0] approach(input logic [COUNTWIDTH-1:0] cur,
                                                       input logic [COUNTWIDTH-1:0] tgt);
      if (cur < tgt)
         return ((tgt - cur) <= STEPV) ? tgt : cur + STEPV;
      else if (cur > tgt)
         return ((cur - tgt) <= STEPV) ? tgt : cur - STEPV;
      else
         return cur;
   endfunction

   always_comb begin
      gray = idx_q ^ (idx_q >> 1);
      tr   = gray[2] ? DMAX : '0;
      tg   = gray[1] ? DMAX : '0;
      tb   = gray[0] ? DMAX : '0;
      fr   = approach(r_q, tr);
      fg   = approach(g_q, tg);
      fb   = approach(b_q, tb);
   end

   always_comb begin
      state_d = state_q;
      saved_d = saved_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      r_d     = r_q;
      g_d     = g_q;
      b_d     = b_q;
      if (btn_pause) begin
         case (state_q)
            FADE, HOLD: begin
               saved_d = state_q;
               state_d = PAUSE;
            end
            PAUSE:   state_d = saved_q;
            default: ;
         endcase
      end else if (btn_next) begin
         idx_d = idx_q + 3'd1;
         case (state_q)
            IDLE: state_d = FADE;
            PAUSE: begin
               saved_d = FADE;
               hold_d  = '0;
            end
            default: begin
               state_d = FADE;
               hold_d  = '0;
            end
         endcase
      end else if (tick) begin
         case (state_q)
            IDLE: begin
               idx_d   = idx_q + 3'd1;
               state_d = FADE;
            end
            FADE: begin
               r_d = fr;
               g_d = fg;
               b_d = fb;
               if (fr == tr && fg == tg && fb == tb) begin
                  state_d = HOLD;
                  hold_d  = '0;
               end
            end
            HOLD: begin
               if (hold_q == HLAST) begin
                  idx_d   = idx_q + 3'd1;
                  state_d = FADE;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         saved_q <= FADE;
         idx_q   <= '0;
         hold_q  <= '0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
      end
   end

   assign duty_r    = r_q;
   assign duty_g    = g_q;
   assign duty_b    = b_q;
   assign color_idx = idx_q;
   assign state     = state_q;
   assign paused    = (state_q == PAUSE);

endmodule

// File: tb/tb_led_fade_scheduler.sv
// Bench for led_fade_scheduler: a vector table, hand sequences for fade/hold/pause
// corners, and random stimulus checked against a per-instance behavioural model.
module tb_led_fade_scheduler;

   logic clk = 1'b0;
   logic rst, tick, btn_next, btn_pause;
   logic [9:0] r0, g0, b0, r1, g1, b1;
   logic [2:0] i0, i1;
   logic [1:0] s0, s1;
   logic       p0, p1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_fade_scheduler #(.COUNTWIDTH(10), .DUTY_MAX(50), .STEP(1), .HOLD_TICKS(20)) dut0 (
      .clk(clk), .rst(rst), .tick(tick), .btn_next(btn_next), .btn_pause(btn_pause),
      .duty_r(r0), .duty_g(g0), .duty_b(b0), .color_idx(i0), .state(s0), .paused(p0));

   led_fade_scheduler #(.COUNTWIDTH(10), .DUTY_MAX(50), .STEP(7), .HOLD_TICKS(3)) dut1 (
      .clk(clk), .rst(rst), .tick(tick), .btn_next(btn_next), .btn_pause(btn_pause),
      .duty_r(r1), .duty_g(g1), .duty_b(b1), .color_idx(i1), .state(s1), .paused(p1));

   // Reference model: states as 0 idle, 1 fade, 2 hold, 3 pause; duties as plain ints.
   int p_max[2]  = '{50, 50};
   int p_step[2] = '{1, 7};
   int p_hold[2] = '{20, 3};
   int m_st[2], m_sv[2], m_idx[2], m_hold[2];
   int m_d[2][3];

   task automatic model_step(input int k, input bit r, input bit t, input bit n, input bit p);
      int g, tgt;
      bit done;
      if (r) begin
         m_st[k] = 0; m_sv[k] = 1; m_idx[k] = 0; m_hold[k] = 0;
         for (int c = 0; c < 3; c++) m_d[k][c] = 0;
      end else if (p) begin
         if (m_st[k] == 1 || m_st[k] == 2) begin
            m_sv[k] = m_st[k];
            m_st[k] = 3;
         end else if (m_st[k] == 3) begin
            m_st[k] = m_sv[k];
         end
      end else if (n) begin
         m_idx[k] = (m_idx[k] + 1) % 8;
         if (m_st[k] == 3) begin
            m_sv[k] = 1; m_hold[k] = 0;
         end else begin
            if (m_st[k] != 0) m_hold[k] = 0;
            m_st[k] = 1;
         end
      end else if (t) begin
         if (m_st[k] == 0) begin
            m_idx[k] = (m_idx[k] + 1) % 8;
            m_st[k]  = 1;
         end else if (m_st[k] == 1) begin
            g    = m_idx[k] ^ (m_idx[k] >> 1);
            done = 1'b1;
            for (int c = 0; c < 3; c++) begin
               tgt = ((g >> (2 - c)) & 1) != 0 ? p_max[k] : 0;
               if (m_d[k][c] < tgt)
                  m_d[k][c] = (m_d[k][c] + p_step[k] > tgt) ? tgt : m_d[k][c] + p_step[k];
               else if (m_d[k][c] > tgt)
                  m_d[k][c] = (m_d[k][c] - p_step[k] < tgt) ? tgt : m_d[k][c] - p_step[k];
               if (m_d[k][c] != tgt) done = 1'b0;
            end
            if (done) begin
               m_st[k] = 2; m_hold[k] = 0;
            end
         end else if (m_st[k] == 2) begin
            if (m_hold[k] == p_hold[k] - 1) begin
               m_idx[k] = (m_idx[k] + 1) % 8; m_st[k] = 1; m_hold[k] = 0;
            end else begin
               m_hold[k]++;
            end
         end
      end
   endtask

   function automatic longint pack(input int ps, input int st, input int idx,
                                   input int r, input int g, input int b);
      return (longint'(ps) << 35) | (longint'(st) << 33) | (longint'(idx) << 30) |
             (longint'(r) << 20) | (longint'(g) << 10) | longint'(b);
   endfunction

   function automatic longint dut_pack(input int k);
      if (k == 0) return pack(int'(p0), int'(s0), int'(i0), int'(r0), int'(g0), int'(b0));
      return pack(int'(p1), int'(s1), int'(i1), int'(r1), int'(g1), int'(b1));
   endfunction

   function automatic longint model_pack(input int k);
      return pack((m_st[k] == 3) ? 1 : 0, m_st[k], m_idx[k], m_d[k][0], m_d[k][1], m_d[k][2]);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check64(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: drive inputs, let the edge sample them, then advance both models.
   task automatic apply(input bit r, input bit t, input bit n, input bit p);
      rst = r; tick = t; btn_next = n; btn_pause = p;
      @(posedge clk);
      #1;
      model_step(0, r, t, n, p);
      model_step(1, r, t, n, p);
      rst = 1'b0; tick = 1'b0; btn_next = 1'b0; btn_pause = 1'b0;
   endtask

   task automatic ticks(input int cnt);
      for (int j = 0; j < cnt; j++) apply(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   typedef struct {
      bit r, t, n, p;
      int st, idx, dr, dg, db;
   } vec_t;

   vec_t tbl[16];

   initial begin
      rst = 1'b1; tick = 1'b0; btn_next = 1'b0; btn_pause = 1'b0;

      tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 1, 0, 0, 1, 1, 0, 0, 0};
      tbl[3]  = '{0, 1, 0, 0, 1, 1, 0, 0, 1};
      tbl[4]  = '{0, 1, 0, 0, 1, 1, 0, 0, 2};
      tbl[5]  = '{0, 0, 0, 1, 3, 1, 0, 0, 2};
      tbl[6]  = '{0, 1, 0, 0, 3, 1, 0, 0, 2};
      tbl[7]  = '{0, 0, 1, 0, 3, 2, 0, 0, 2};
      tbl[8]  = '{0, 0, 0, 1, 1, 2, 0, 0, 2};
      tbl[9]  = '{0, 1, 0, 0, 1, 2, 0, 1, 3};
      tbl[10] = '{0, 1, 1, 0, 1, 3, 0, 1, 3};
      tbl[11] = '{0, 1, 0, 0, 1, 3, 0, 2, 2};
      tbl[12] = '{0, 0, 1, 1, 3, 3, 0, 2, 2};
      tbl[13] = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
      tbl[14] = '{0, 0, 1, 0, 1, 1, 0, 0, 0};
      tbl[15] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};

      for (int i = 0; i < 16; i++) begin
         apply(tbl[i].r, tbl[i].t, tbl[i].n, tbl[i].p);
         check64($sformatf("vec%0d", i), dut_pack(0),
                 pack((tbl[i].st == 3) ? 1 : 0, tbl[i].st, tbl[i].idx,
                      tbl[i].dr, tbl[i].dg, tbl[i].db));
      end

      // First fade up on blue, hold, advance to green, then blue fades down.
      apply(1'b1, 1'b0, 1'b0, 1'b0);
      ticks(1);
      check("A_start", dut_pack(0) == pack(0, 1, 1, 0, 0, 0) ? 1 : 0, 1);
      ticks(49);
      check("A_b49_state", int'(s0), 1);
      check("A_b49", int'(b0), 49);
      ticks(1);
      check64("A_b50_hold", dut_pack(0), pack(0, 2, 1, 0, 0, 50));
      ticks(19);
      check64("A_hold19", dut_pack(0), pack(0, 2, 1, 0, 0, 50));
      ticks(1);
      check64("A_adv2", dut_pack(0), pack(0, 1, 2, 0, 0, 50));
      ticks(49);
      check64("A_g49", dut_pack(0), pack(0, 1, 2, 0, 49, 50));
      ticks(1);
      check64("A_g50_hold", dut_pack(0), pack(0, 2, 2, 0, 50, 50));
      ticks(20);
      check64("A_adv3", dut_pack(0), pack(0, 1, 3, 0, 50, 50));
      ticks(1);
      check64("A_b_down", dut_pack(0), pack(0, 1, 3, 0, 50, 49));

      // STEP=7 instance: up ramp clamps at 50 on tick 8, down ramp clamps at 0.
      apply(1'b1, 1'b0, 1'b0, 1'b0);
      ticks(1);
      for (int k = 1; k <= 8; k++) begin
         ticks(1);
         check($sformatf("B_up%0d", k), int'(b1), (7 * k > 50) ? 50 : 7 * k);
      end
      check("B_up_hold", int'(s1), 2);
      ticks(3);
      check64("B_adv2", dut_pack(1), pack(0, 1, 2, 0, 0, 50));
      ticks(8);
      check64("B_g_hold", dut_pack(1), pack(0, 2, 2, 0, 50, 50));
      ticks(3);
      check("B_adv3", int'(i1), 3);
      for (int k = 1; k <= 8; k++) begin
         ticks(1);
         check($sformatf("B_dn%0d", k), int'(b1), (50 - 7 * k < 0) ? 0 : 50 - 7 * k);
      end
      check64("B_dn_hold", dut_pack(1), pack(0, 2, 3, 0, 50, 0));

      // Pause freezes a fade mid-way; resume continues from the frozen duty.
      apply(1'b1, 1'b0, 1'b0, 1'b0);
      ticks(21);
      check("C_b20", int'(b0), 20);
      apply(1'b0, 1'b0, 1'b0, 1'b1);
      check64("C_paused", dut_pack(0), pack(1, 3, 1, 0, 0, 20));
      ticks(10);
      check64("C_frozen", dut_pack(0), pack(1, 3, 1, 0, 0, 20));
      apply(1'b0, 1'b0, 1'b0, 1'b1);
      check64("C_resume", dut_pack(0), pack(0, 1, 1, 0, 0, 20));
      ticks(1);
      check("C_b21", int'(b0), 21);

      // Skip to index 7 (red), fade, wrap to 0 and fade out, reset mid-fade.
      apply(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 7; k++) apply(1'b0, 1'b0, 1'b1, 1'b0);
      check64("D_idx7", dut_pack(0), pack(0, 1, 7, 0, 0, 0));
      ticks(50);
      check64("D_red", dut_pack(0), pack(0, 2, 7, 50, 0, 0));
      apply(1'b0, 1'b0, 1'b1, 1'b0);
      check64("D_wrap", dut_pack(0), pack(0, 1, 0, 50, 0, 0));
      ticks(10);
      check64("D_r40", dut_pack(0), pack(0, 1, 0, 40, 0, 0));
      apply(1'b1, 1'b1, 1'b0, 1'b0);
      check64("D_reset", dut_pack(0), pack(0, 0, 0, 0, 0, 0));

      // Random stimulus against the model on both instances.
      apply(1'b1, 1'b0, 1'b0, 1'b0);
      for (int cyc = 0; cyc < 5000; cyc++) begin
         apply($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);
         check64($sformatf("rnd0_c%0d", cyc), dut_pack(0), model_pack(0));
         check64($sformatf("rnd1_c%0d", cyc), dut_pack(1), model_pack(1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
